// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Start/busy/done handshake and result bundle of serial_subtractor.
//            The overflow signal exists only when SERIAL_SUB_OVF_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface serial_subtractor_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             zero;
`ifdef SERIAL_SUB_OVF_EN
   logic             overflow;
`endif

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out, zero
`ifdef SERIAL_SUB_OVF_EN
      , input overflow
`endif
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out, zero
`ifdef SERIAL_SUB_OVF_EN
      , output overflow
`endif
   );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial two's-complement a - b, LSB first, one bit per clock.
//            Optional signed overflow flag via macro SERIAL_SUB_OVF_EN.
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_subtractor_if.slave bus
);
   localparam int                 c_cnt_w = $clog2(WIDTH) + 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-2:0]   r_work;
   logic               r_br;
   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH-1:0]   r_diff;
   logic               r_borrow_out;
   logic               r_zero;
   logic               w_d;
   logic               w_br_next;
   logic               w_last;
   logic [WIDTH-1:0]   w_result;

   assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   assign w_last    = (r_cnt == c_last);
   // The current difference bit plus the WIDTH-1 bits already shifted in.
   assign w_result  = {w_d, r_work};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            bus.busy = 1'b1;
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            bus.done     = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a          <= '0;
         r_b          <= '0;
         r_work       <= '0;
         r_br         <= 1'b0;
         r_cnt        <= '0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
         r_zero       <= 1'b1;
      end else begin
         if (r_state == IDLE && bus.start) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_work <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
         end
         if (r_state == RUN) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_work <= w_result[WIDTH-1:1];
            r_br   <= w_br_next;
            r_cnt  <= r_cnt + c_cnt_w'(1);
            // Results change only here, so they stay stable across the next run.
            if (w_last) begin
               r_diff       <= w_result;
               r_borrow_out <= w_br_next;
               r_zero       <= (w_result == '0);
            end
         end
      end
   end

   assign bus.diff       = r_diff;
   assign bus.borrow_out = r_borrow_out;
   assign bus.zero       = r_zero;

`ifdef SERIAL_SUB_OVF_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_msb    <= 1'b0;
         r_b_msb    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (r_state == IDLE && bus.start) begin
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
         end
         if (r_state == RUN && w_last) begin
            r_overflow <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
         end
      end
   end

   assign bus.overflow = r_overflow;
`endif
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor at WIDTH 8 and 32.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;
   typedef struct {
      logic [31:0] diff;
      logic        bo;
      logic        zero;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       bo;
      logic       zero;
      logic       ovf;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   cyc;
   int   done8_cnt;
   int   done32_cnt;
   int   done32_cyc[$];
   exp_t q8[$];
   exp_t q32[$];
   exp_t e8;
   exp_t e32;
   vec_t vecs[16];

   serial_subtractor_if #(.WIDTH(8))  bus8();
   serial_subtractor_if #(.WIDTH(32)) bus32();

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   serial_subtractor #(.WIDTH(32)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst_n === 1'b1 && bus8.done === 1'b1) begin
         done8_cnt++;
         if (q8.size() == 0) begin
            check("done8_unexpected", 32'd1, 32'd0);
         end else begin
            e8 = q8.pop_front();
            check("diff8", {24'd0, bus8.diff}, e8.diff);
            check("borrow8", {31'd0, bus8.borrow_out}, {31'd0, e8.bo});
            check("zero8", {31'd0, bus8.zero}, {31'd0, e8.zero});
`ifdef SERIAL_SUB_OVF_EN
            check("ovf8", {31'd0, bus8.overflow}, {31'd0, e8.ovf});
`endif
         end
      end
      if (rst_n === 1'b1 && bus32.done === 1'b1) begin
         done32_cnt++;
         done32_cyc.push_back(cyc);
         if (q32.size() == 0) begin
            check("done32_unexpected", 32'd1, 32'd0);
         end else begin
            e32 = q32.pop_front();
            check("diff32", bus32.diff, e32.diff);
            check("borrow32", {31'd0, bus32.borrow_out}, {31'd0, e32.bo});
            check("zero32", {31'd0, bus32.zero}, {31'd0, e32.zero});
`ifdef SERIAL_SUB_OVF_EN
            check("ovf32", {31'd0, bus32.overflow}, {31'd0, e32.ovf});
`endif
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic exp_t mk(input logic [31:0] d, input logic bo, input logic z, input logic ov);
      exp_t e;
      e.diff = d;
      e.bo   = bo;
      e.zero = z;
      e.ovf  = ov;
      return e;
   endfunction

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input exp_t e);
      step();
      bus8.a     = a;
      bus8.b     = b;
      bus8.start = 1'b1;
      q8.push_back(e);
      step();
      bus8.start = 1'b0;
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
   endtask

   task automatic wait_done8(input int prev, input int limit);
      int n;
      n = 0;
      while (done8_cnt == prev && n < limit) begin
         step();
         n++;
      end
      if (done8_cnt == prev) check("timeout8", 32'd0, 32'd1);
   endtask

   initial begin
      int prev;
      logic [7:0] ra;
      logic [7:0] rb;
      logic [7:0] rd;
      checks     = 0;
      errors     = 0;
      cyc        = 0;
      done8_cnt  = 0;
      done32_cnt = 0;

      // a, b, diff, borrow, zero, overflow
      vecs[0] = '{8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{8'h55, 8'hAA, 8'hAB, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{8'hC8, 8'h37, 8'h91, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0};
      for (int i = 10; i < 16; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rd = ra - rb;
         vecs[i] = '{ra, rb, rd, (ra < rb), (rd == 8'h00),
                     ((ra[7] != rb[7]) && (rd[7] != ra[7]))};
      end

      rst_n       = 1'b0;
      bus8.start  = 1'b0;
      bus8.a      = '0;
      bus8.b      = '0;
      bus32.start = 1'b0;
      bus32.a     = '0;
      bus32.b     = '0;
      repeat (3) step();
      check("rst_busy8", {31'd0, bus8.busy}, 32'd0);
      check("rst_done8", {31'd0, bus8.done}, 32'd0);
      check("rst_diff8", {24'd0, bus8.diff}, 32'd0);
      check("rst_zero8", {31'd0, bus8.zero}, 32'd1);
      check("rst_borrow8", {31'd0, bus8.borrow_out}, 32'd0);
      check("rst_diff32", bus32.diff, 32'd0);
      check("rst_zero32", {31'd0, bus32.zero}, 32'd1);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf8", {31'd0, bus8.overflow}, 32'd0);
`endif
      rst_n = 1'b1;
      step();

      // Exact handshake timing on the first vector, then a start during DONE.
      issue8(vecs[0].a, vecs[0].b, mk({24'd0, vecs[0].diff}, vecs[0].bo, vecs[0].zero, vecs[0].ovf));
      check("t_busy_first", {31'd0, bus8.busy}, 32'd1);
      check("t_done_first", {31'd0, bus8.done}, 32'd0);
      repeat (7) step();
      check("t_busy_last", {31'd0, bus8.busy}, 32'd1);
      check("t_done_early", {31'd0, bus8.done}, 32'd0);
      step();
      check("t_done_pulse", {31'd0, bus8.done}, 32'd1);
      check("t_busy_done", {31'd0, bus8.busy}, 32'd0);
      bus8.a     = 8'h10;
      bus8.b     = 8'h01;
      bus8.start = 1'b1;
      step();
      bus8.start = 1'b0;
      check("t_done_width", {31'd0, bus8.done}, 32'd0);
      check("t_start_in_done", {31'd0, bus8.busy}, 32'd0);
      step();
      check("t_start_in_done2", {31'd0, bus8.busy}, 32'd0);

      for (int i = 1; i < 16; i++) begin
         prev = done8_cnt;
         issue8(vecs[i].a, vecs[i].b, mk({24'd0, vecs[i].diff}, vecs[i].bo, vecs[i].zero, vecs[i].ovf));
         wait_done8(prev, 20);
      end

      // Start pulsed mid-run with other operands must be ignored.
      prev = done8_cnt;
      issue8(8'h03, 8'h05, mk(32'h0000_00FE, 1'b1, 1'b0, 1'b0));
      repeat (3) step();
      bus8.a     = 8'h10;
      bus8.b     = 8'h01;
      bus8.start = 1'b1;
      step();
      bus8.start = 1'b0;
      wait_done8(prev, 20);
      repeat (12) step();
      check("ignored_start_dones", done8_cnt, prev + 1);

      // Results hold through the following operation until its done.
      prev = done8_cnt;
      issue8(8'h80, 8'h01, mk(32'h0000_007F, 1'b0, 1'b0, 1'b1));
      repeat (4) step();
      check("hold_diff", {24'd0, bus8.diff}, 32'h0000_00FE);
      check("hold_borrow", {31'd0, bus8.borrow_out}, 32'd1);
      wait_done8(prev, 20);

      // Reset asserted mid-run: immediate reset values, no later done.
      prev = done8_cnt;
      issue8(8'h03, 8'h05, mk(32'h0000_00FE, 1'b1, 1'b0, 1'b0));
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, bus8.busy}, 32'd0);
      check("mid_rst_done", {31'd0, bus8.done}, 32'd0);
      check("mid_rst_diff", {24'd0, bus8.diff}, 32'd0);
      check("mid_rst_zero", {31'd0, bus8.zero}, 32'd1);
      q8.delete();
      step();
      rst_n = 1'b1;
      repeat (12) step();
      check("mid_rst_no_done", done8_cnt, prev);
      check("mid_rst_idle", {31'd0, bus8.busy}, 32'd0);

      // start held high on the 32-bit instance: back-to-back issue.
      step();
      bus32.a     = 32'd100;
      bus32.b     = 32'd1;
      bus32.start = 1'b1;
      q32.push_back(mk(32'd99, 1'b0, 1'b0, 1'b0));
      step();
      bus32.a = 32'd0;
      bus32.b = 32'd1;
      q32.push_back(mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
      repeat (34) step();
      bus32.a = 32'hFFFF_FFFF;
      bus32.b = 32'hFFFF_FFFF;
      q32.push_back(mk(32'd0, 1'b0, 1'b1, 1'b0));
      repeat (34) step();
      bus32.start = 1'b0;
      begin
         int n;
         n = 0;
         while (done32_cnt < 3 && n < 200) begin
            step();
            n++;
         end
      end
      check("b2b_done_count", done32_cnt, 32'd3);
      if (done32_cyc.size() >= 3) begin
         check("b2b_spacing1", done32_cyc[1] - done32_cyc[0], 32'd34);
         check("b2b_spacing2", done32_cyc[2] - done32_cyc[1], 32'd34);
      end
      repeat (40) step();
      check("b2b_no_extra", done32_cnt, 32'd3);
      check("q8_drained", q8.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
